elixirchip_es1_spu_op_mem_reader: RTL and testbench

Burst read sequencer that sits directly upstream of `elixirchip_es1_spu_op_mem` on its read port. It accepts a (start address, length) command and issues one read per cycle on `s_raddr`/`s_rvalid`. It tracks the fixed read latency and captures `m_rdata` into a credit-protected output FIFO. The FIFO drains to a valid/ready stream, so downstream backpressure never loses a word even though the memory read port has no stall.

---
 rtl/elixirchip_es1_spu_op_pkg.sv | 17 +
 rtl/elixirchip_es1_spu_op_mem_reader_fifo.sv | 63 ++++++
 rtl/elixirchip_es1_spu_op_mem_reader.sv | 185 ++++++++++++++++++
 tb/tb_elixirchip_es1_spu_op_mem_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_op_pkg.sv
// Shared types for the SPU op-memory helpers: reader FSM states and the
// counter-width helper used to size occupancy counters.
package elixirchip_es1_spu_op_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN,
        RD_DONE
    } rd_state_t;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mem_reader_fifo.sv
// Flip-flop FIFO with clock enable and occupancy count, used as the
// credit-protected output buffer of the op-memory burst reader.
module elixirchip_es1_spu_op_mem_reader_fifo
    import elixirchip_es1_spu_op_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CW    = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cke,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (cke) begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (cke && push && !pop) |-> (count != CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        (cke && pop) |-> (count != '0));

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_reader.sv
// Burst read sequencer for the SPU op memory: issues one read per cycle under
// FIFO credit and re-times the fixed-latency read data onto a valid/ready stream.
// Optional m_last output: define ELIXIRCHIP_ES1_SPU_OP_MEM_READER_LAST_EN.
module elixirchip_es1_spu_op_mem_reader
    import elixirchip_es1_spu_op_pkg::*;
#(
    parameter int RLATENCY   = 2,
    parameter int DATA_BITS  = 18,
    parameter int ADDR_BITS  = 10,
    parameter int MEM_SIZE   = 2 ** ADDR_BITS,
    parameter int LEN_BITS   = ADDR_BITS + 1,
    parameter int FIFO_DEPTH = RLATENCY + 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic [ADDR_BITS-1:0] s_cmd_addr,
    input  logic [LEN_BITS-1:0]  s_cmd_len,
    input  logic                 s_cmd_valid,
    output logic                 s_cmd_ready,
    output logic [ADDR_BITS-1:0] m_raddr,
    output logic                 m_rvalid,
    input  logic [DATA_BITS-1:0] s_rdata,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_done
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_LAST_EN
    ,
    output logic                 m_last
`endif
);

    localparam int CW = cnt_bits(FIFO_DEPTH);
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_LAST_EN
    localparam int FW = DATA_BITS + 1;
`else
    localparam int FW = DATA_BITS;
`endif

    rd_state_t            state, state_next;
    logic [ADDR_BITS-1:0] addr, addr_next;
    logic [LEN_BITS-1:0]  remaining, rem_next;
    logic [ADDR_BITS-1:0] raddr_next;
    logic                 rvalid_next;
    logic [RLATENCY-1:0]  sr;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 can_issue;
    logic [FW-1:0]        fifo_in;
    logic [FW-1:0]        fifo_out;

    function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
        return (a == ADDR_BITS'(MEM_SIZE - 1)) ? '0 : a + 1'b1;
    endfunction

    assign push = sr[RLATENCY-1];
    assign pop  = !fifo_empty && m_ready;
    // A pop in the same cycle frees the slot the new read will need.
    assign can_issue = (int'(fifo_count) + int'(inflight)) < (FIFO_DEPTH + int'(pop));

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        rem_next    = remaining;
        raddr_next  = m_raddr;
        rvalid_next = 1'b0;
        case (state)
            RD_IDLE: begin
                if (s_cmd_valid) begin
                    if (s_cmd_len == '0) begin
                        state_next = RD_DONE;
                    end else begin
                        rvalid_next = 1'b1;
                        raddr_next  = s_cmd_addr;
                        addr_next   = addr_inc(s_cmd_addr);
                        rem_next    = s_cmd_len - 1'b1;
                        state_next  = (s_cmd_len == LEN_BITS'(1)) ? RD_DRAIN : RD_RUN;
                    end
                end
            end
            RD_RUN: begin
                if (can_issue) begin
                    rvalid_next = 1'b1;
                    raddr_next  = addr;
                    addr_next   = addr_inc(addr);
                    rem_next    = remaining - 1'b1;
                    if (remaining == LEN_BITS'(1)) begin
                        state_next = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (inflight == '0 &&
                    (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: state_next = RD_IDLE;
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RD_IDLE;
        end else if (cke) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            m_raddr   <= '0;
            m_rvalid  <= 1'b0;
            sr        <= '0;
            inflight  <= '0;
        end else if (cke) begin
            addr      <= addr_next;
            remaining <= rem_next;
            m_raddr   <= raddr_next;
            m_rvalid  <= rvalid_next;
            sr[0]     <= m_rvalid;
            for (int unsigned i = 1; i < RLATENCY; i++) begin
                sr[i] <= sr[i-1];
            end
            inflight  <= inflight + CW'(rvalid_next) - CW'(push);
        end
    end

`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_LAST_EN
    // The last flag rides a twin of the issue pipeline so it lands with its word.
    logic                rvalid_last;
    logic [RLATENCY-1:0] sr_last;
    logic                issue_last;

    assign issue_last = rvalid_next &&
        ((state == RD_IDLE) ? (s_cmd_len == LEN_BITS'(1)) : (remaining == LEN_BITS'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_last <= 1'b0;
            sr_last     <= '0;
        end else if (cke) begin
            rvalid_last <= issue_last;
            sr_last[0]  <= rvalid_last;
            for (int unsigned i = 1; i < RLATENCY; i++) begin
                sr_last[i] <= sr_last[i-1];
            end
        end
    end

    assign fifo_in = {sr_last[RLATENCY-1], s_rdata};
    assign m_last  = fifo_out[DATA_BITS];
`else
    assign fifo_in = s_rdata;
`endif

    elixirchip_es1_spu_op_mem_reader_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .cke       (cke),
        .push      (push),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_data      = fifo_out[DATA_BITS-1:0];
    assign m_valid     = !fifo_empty;
    assign m_done      = (state == RD_DONE);
    assign s_cmd_ready = (state == RD_IDLE) && reset_n;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_reader.sv
// Directed bench for the op-memory burst reader with a fixed-latency
// data=address memory model sharing the reader's clock enable.
module tb_elixirchip_es1_spu_op_mem_reader;

    localparam int RLATENCY   = 2;
    localparam int DATA_BITS  = 18;
    localparam int ADDR_BITS  = 10;
    localparam int LEN_BITS   = 11;
    localparam int FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 cke;
    logic [ADDR_BITS-1:0] s_cmd_addr;
    logic [LEN_BITS-1:0]  s_cmd_len;
    logic                 s_cmd_valid;
    logic                 s_cmd_ready;
    logic [ADDR_BITS-1:0] m_raddr;
    logic                 m_rvalid;
    logic [DATA_BITS-1:0] s_rdata;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_done;
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_LAST_EN
    logic                 m_last;
`endif

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_mem_reader #(
        .RLATENCY   (RLATENCY),
        .DATA_BITS  (DATA_BITS),
        .ADDR_BITS  (ADDR_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cke         (cke),
        .s_cmd_addr  (s_cmd_addr),
        .s_cmd_len   (s_cmd_len),
        .s_cmd_valid (s_cmd_valid),
        .s_cmd_ready (s_cmd_ready),
        .m_raddr     (m_raddr),
        .m_rvalid    (m_rvalid),
        .s_rdata     (s_rdata),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_done      (m_done)
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_LAST_EN
        ,
        .m_last      (m_last)
`endif
    );

    // Memory model: data equals address, RLATENCY register stages, shares cke.
    logic [DATA_BITS-1:0] mem_pipe [RLATENCY];
    always_ff @(posedge clk) begin
        if (cke) begin
            mem_pipe[0] <= DATA_BITS'(m_raddr);
            for (int i = 1; i < RLATENCY; i++) mem_pipe[i] <= mem_pipe[i-1];
        end
    end
    assign s_rdata = mem_pipe[RLATENCY-1];

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_BITS-1:0] iss_addr[$];
    int                   iss_cyc[$];
    logic [DATA_BITS-1:0] out_data[$];
    int                   out_cyc[$];
    int                   done_cyc[$];
    int                   ready_after_done;
    int                   accept_wait;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, then records cycle-by-cycle activity for ncyc cycles.
    // Cycle 1 is the cycle right after the accepting edge.
    task automatic run_cmd(input logic [ADDR_BITS-1:0] a, input logic [LEN_BITS-1:0] len,
                           input int ncyc, input int hold, input bit toggle);
        iss_addr.delete(); iss_cyc.delete(); out_data.delete(); out_cyc.delete();
        done_cyc.delete();
        ready_after_done = -1;
        cke = 1'b1;
        m_ready = 1'b1;
        s_cmd_addr = a;
        s_cmd_len = len;
        s_cmd_valid = 1'b1;
        accept_wait = 0;
        while (s_cmd_ready !== 1'b1 && accept_wait < 10) begin
            tick();
            accept_wait++;
        end
        n_cmp++;
        if (s_cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_accept: s_cmd_ready=%b after %0d cycles, required 1", s_cmd_ready, accept_wait);
        end
        tick();
        s_cmd_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) tick();
            cke = toggle ? (c % 2 == 1) : 1'b1;
            m_ready = (c > hold);
            #1;
            if (cke) begin
                if (m_rvalid === 1'b1) begin
                    iss_addr.push_back(m_raddr);
                    iss_cyc.push_back(c);
                end
                if (m_valid === 1'b1 && m_ready) begin
                    out_data.push_back(m_data);
                    out_cyc.push_back(c);
                end
                if (m_done === 1'b1) done_cyc.push_back(c);
            end
            if (ready_after_done < 0 && done_cyc.size() > 0 && m_done !== 1'b1)
                ready_after_done = int'(s_cmd_ready);
        end
        cke = 1'b1;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cke = 1'b1;
        s_cmd_addr = '0;
        s_cmd_len = '0;
        s_cmd_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (s_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", s_cmd_ready); end
        n_cmp++; if (m_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", m_rvalid); end
        n_cmp++; if (m_raddr !== 10'h000) begin n_bad++; $display("FAIL rst_raddr: got %h want 000", m_raddr); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 18'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", m_data); end
        n_cmp++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", m_done); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (s_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", s_cmd_ready); end
        tick();
    endtask

    task automatic test_basic();
        run_cmd(10'h010, 11'd4, 12, 0, 1'b0);
        n_cmp++; if (iss_addr.size() != 4) begin n_bad++; $display("FAIL basic_issue_count: got %0d want 4", iss_addr.size()); end
        for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
            n_cmp++; if (iss_addr[i] !== 10'(16 + i)) begin n_bad++; $display("FAIL basic_raddr[%0d]: got %h want %h", i, iss_addr[i], 10'(16 + i)); end
            n_cmp++; if (iss_cyc[i] != 1 + i) begin n_bad++; $display("FAIL basic_issue_cyc[%0d]: got %0d want %0d", i, iss_cyc[i], 1 + i); end
        end
        n_cmp++; if (out_data.size() != 4) begin n_bad++; $display("FAIL basic_out_count: got %0d want 4", out_data.size()); end
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            n_cmp++; if (out_data[i] !== 18'(16 + i)) begin n_bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, out_data[i], 18'(16 + i)); end
            n_cmp++; if (out_cyc[i] != 4 + i) begin n_bad++; $display("FAIL basic_out_cyc[%0d]: got %0d want %0d", i, out_cyc[i], 4 + i); end
        end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cyc.size()); end
        else begin
            n_cmp++; if (done_cyc[0] != 8) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want 8", done_cyc[0]); end
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_BITS-1:0] exp_a [4];
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        run_cmd(10'h3FE, 11'd4, 12, 0, 1'b0);
        n_cmp++; if (iss_addr.size() != 4 || out_data.size() != 4) begin n_bad++; $display("FAIL wrap_counts: got %0d/%0d want 4/4", iss_addr.size(), out_data.size()); end
        for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
            n_cmp++; if (iss_addr[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_raddr[%0d]: got %h want %h", i, iss_addr[i], exp_a[i]); end
        end
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            n_cmp++; if (out_data[i] !== 18'(exp_a[i])) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, out_data[i], 18'(exp_a[i])); end
        end
    endtask

    task automatic test_backpressure();
        int early;
        run_cmd(10'h020, 11'd16, 45, 20, 1'b0);
        early = 0;
        foreach (iss_cyc[i]) if (iss_cyc[i] <= 21) early++;
        n_cmp++; if (early != FIFO_DEPTH) begin n_bad++; $display("FAIL bp_stalled_issues: got %0d want %0d", early, FIFO_DEPTH); end
        n_cmp++; if (iss_cyc.size() != 16) begin n_bad++; $display("FAIL bp_issue_total: got %0d want 16", iss_cyc.size()); end
        else begin
            n_cmp++; if (iss_cyc[4] != 22) begin n_bad++; $display("FAIL bp_resume_cyc: got %0d want 22", iss_cyc[4]); end
        end
        n_cmp++; if (out_data.size() != 16) begin n_bad++; $display("FAIL bp_out_count: got %0d want 16", out_data.size()); end
        for (int i = 0; i < 16 && i < out_data.size(); i++) begin
            n_cmp++; if (out_data[i] !== 18'(32 + i)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data[i], 18'(32 + i)); end
        end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", done_cyc.size()); end
        else begin
            n_cmp++; if (done_cyc[0] != 37) begin n_bad++; $display("FAIL bp_done_cyc: got %0d want 37", done_cyc[0]); end
        end
    endtask

    task automatic test_zero_len();
        run_cmd(10'h123, 11'd0, 4, 0, 1'b0);
        n_cmp++; if (iss_addr.size() != 0) begin n_bad++; $display("FAIL zero_issues: got %0d want 0", iss_addr.size()); end
        n_cmp++; if (out_data.size() != 0) begin n_bad++; $display("FAIL zero_outputs: got %0d want 0", out_data.size()); end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_cyc.size()); end
        else begin
            n_cmp++; if (done_cyc[0] != 1) begin n_bad++; $display("FAIL zero_done_cyc: got %0d want 1", done_cyc[0]); end
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(10'h005, 11'd1, 6, 0, 1'b0);
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != 5) begin n_bad++; $display("FAIL b2b_first_done: got %0d entries want one at cycle 5", done_cyc.size()); end
        n_cmp++; if (ready_after_done != 1) begin n_bad++; $display("FAIL b2b_ready_after_done: got %0d want 1", ready_after_done); end
        run_cmd(10'h006, 11'd1, 6, 0, 1'b0);
        n_cmp++; if (accept_wait != 0) begin n_bad++; $display("FAIL b2b_accept_wait: got %0d want 0", accept_wait); end
        n_cmp++; if (out_data.size() != 1 || out_data[0] !== 18'h006) begin n_bad++; $display("FAIL b2b_second_data: got %0d words want one word 006", out_data.size()); end
    endtask

    task automatic test_reset_mid_burst();
        run_cmd(10'h040, 11'd8, 6, 0, 1'b0);
        n_cmp++; if (out_data.size() != 3) begin n_bad++; $display("FAIL mid_pre_words: got %0d want 3", out_data.size()); end
        n_cmp++; if (m_rvalid !== 1'b1 || m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_active: got rvalid=%b valid=%b want 1/1", m_rvalid, m_valid); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (m_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rvalid: got %b want 0", m_rvalid); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 18'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h want 0", m_data); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_cmd(10'h100, 11'd2, 12, 0, 1'b0);
        n_cmp++; if (iss_addr.size() != 2) begin n_bad++; $display("FAIL mid_new_issues: got %0d want 2", iss_addr.size()); end
        n_cmp++; if (out_data.size() != 2) begin n_bad++; $display("FAIL mid_new_words: got %0d want 2", out_data.size()); end
        for (int i = 0; i < 2 && i < out_data.size(); i++) begin
            n_cmp++; if (out_data[i] !== 18'(256 + i)) begin n_bad++; $display("FAIL mid_new_data[%0d]: got %h want %h", i, out_data[i], 18'(256 + i)); end
        end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != 6) begin n_bad++; $display("FAIL mid_new_done: got %0d entries want one at cycle 6", done_cyc.size()); end
    endtask

    task automatic test_cke_toggle();
        run_cmd(10'h080, 11'd6, 40, 0, 1'b1);
        n_cmp++; if (iss_addr.size() != 6) begin n_bad++; $display("FAIL cke_issues: got %0d want 6", iss_addr.size()); end
        for (int i = 0; i < 6 && i < iss_addr.size(); i++) begin
            n_cmp++; if (iss_addr[i] !== 10'(128 + i)) begin n_bad++; $display("FAIL cke_raddr[%0d]: got %h want %h", i, iss_addr[i], 10'(128 + i)); end
        end
        n_cmp++; if (out_data.size() != 6) begin n_bad++; $display("FAIL cke_words: got %0d want 6", out_data.size()); end
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            n_cmp++; if (out_data[i] !== 18'(128 + i)) begin n_bad++; $display("FAIL cke_data[%0d]: got %h want %h", i, out_data[i], 18'(128 + i)); end
        end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL cke_done_count: got %0d want 1", done_cyc.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_burst();
        test_cke_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
